// File: rtl/pipeline_hazard_ctrl.sv
// Front-end hazard sequencer for the 5-stage RISC-V pipeline: PC enable, IF/ID
// stall/flush, ID/EX bubble and back-end hold, plus saturating stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_en,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
    input  logic                      id_use_rs1,
    input  logic                      id_use_rs2,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_redirect,
    input  logic                      imem_ready,
    input  logic                      dmem_req,
    input  logic                      dmem_ready,
    output logic                      pc_en,
    output logic                      if_id_stall,
    output logic                      if_id_flush,
    output logic                      id_ex_bubble,
    output logic                      back_stall,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_DWAIT = 2'd2,
        S_IWAIT = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic dmem_wait;
    logic eval_en;
    logic eval_dmem;
    logic count_en;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Memory handshakes: a request is outstanding while *_ready is low; the
    // cycle in which ready is high completes it and releases the hold in that cycle.
    assign dmem_wait = dmem_req & ~dmem_ready;
    assign load_use  = ex_mem_read & (ex_rd != '0) &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) |
                        (id_use_rs2 & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_HALT;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HALT:  if (cpu_en) state_d = S_RUN;
            S_RUN: begin
                if (!cpu_en)
                    state_d = S_HALT;
                else if (dmem_wait)
                    state_d = S_DWAIT;
                else if (!ex_redirect && !load_use && !imem_ready)
                    state_d = S_IWAIT;
            end
            // An outstanding data access must complete even when the core is disabled.
            S_DWAIT: if (dmem_ready) state_d = cpu_en ? S_RUN : S_HALT;
            S_IWAIT: begin
                if (!cpu_en)
                    state_d = S_HALT;
                else if (imem_ready)
                    state_d = dmem_wait ? S_DWAIT : S_RUN;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        pc_en        = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        back_stall   = 1'b0;
        eval_en      = 1'b0;
        eval_dmem    = 1'b0;
        case (state_q)
            S_RUN: begin
                if (!cpu_en) if_id_stall = 1'b1;
                else begin
                    eval_en   = 1'b1;
                    eval_dmem = 1'b1;
                end
            end
            S_DWAIT: begin
                if (!dmem_ready) begin
                    back_stall  = 1'b1;
                    if_id_stall = 1'b1;
                end else if (!cpu_en) begin
                    if_id_stall = 1'b1;
                end else begin
                    eval_en = 1'b1;
                end
            end
            S_IWAIT: begin
                if (!cpu_en) begin
                    if_id_stall = 1'b1;
                end else if (!imem_ready) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = ex_redirect;
                end else begin
                    eval_en   = 1'b1;
                    eval_dmem = 1'b1;
                end
            end
            default: if_id_stall = 1'b1;
        endcase

        if (eval_en) begin
            if (eval_dmem && dmem_wait) begin
                back_stall  = 1'b1;
                if_id_stall = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                pc_en        = 1'b1;
            end else if (load_use) begin
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (!imem_ready) begin
                if_id_flush = 1'b1;
            end else begin
                pc_en = 1'b1;
            end
        end
    end

    // The idle hold in HALT is not a hazard stall, so it is not counted.
    assign count_en = cpu_en & (state_q != S_HALT);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (count_en && if_id_stall && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (count_en && if_id_flush && flush_cnt_q != CNT_MAX)
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int RAW = 5;

    localparam int M_HALT  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DWAIT = 2;
    localparam int M_IWAIT = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cpu_en, id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic           imem_ready, dmem_req, dmem_ready;
    logic [RAW-1:0] id_rs1, id_rs2, ex_rd;

    logic        pc_en, if_id_stall, if_id_flush, id_ex_bubble, back_stall;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  dbg_state;

    logic        pc_en4, if_id_stall4, if_id_flush4, id_ex_bubble4, back_stall4;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic [1:0]  dbg_state4;

    int checks = 0;
    int errors = 0;

    int m_mode   = M_HALT;
    int m_stalls = 0;
    int m_flushes = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .back_stall(back_stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dbg_state(dbg_state)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(RAW), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .cpu_en(cpu_en),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en4), .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
        .id_ex_bubble(id_ex_bubble4), .back_stall(back_stall4),
        .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .dbg_state(dbg_state4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Outputs and next mode derived directly from the hazard priority rules.
    task automatic model_eval(output bit pc, output bit st, output bit fl,
                              output bit bu, output bit bk, output int nxt);
        bit lu, dw;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        dw = dmem_req && !dmem_ready;
        pc = 0; st = 0; fl = 0; bu = 0; bk = 0; nxt = m_mode;
        if (m_mode == M_DWAIT && !dmem_ready) begin
            bk = 1; st = 1;
        end else if (!cpu_en || m_mode == M_HALT) begin
            st = 1;
            nxt = cpu_en ? M_RUN : M_HALT;
        end else if (m_mode == M_IWAIT && !imem_ready) begin
            fl = 1; bu = ex_redirect;
        end else begin
            nxt = M_RUN;
            if (m_mode != M_DWAIT && dw) begin
                bk = 1; st = 1; nxt = M_DWAIT;
            end else if (ex_redirect) begin
                fl = 1; bu = 1; pc = 1;
            end else if (lu) begin
                st = 1; bu = 1;
            end else if (!imem_ready) begin
                fl = 1;
                if (m_mode == M_RUN) nxt = M_IWAIT;
            end else begin
                pc = 1;
            end
        end
    endtask

    function automatic longint sat(input int n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // Compare process: check at negedge, advance the model at posedge.
    initial begin
        bit e_pc, e_st, e_fl, e_bu, e_bk;
        int e_nxt;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_mode = M_HALT; m_stalls = 0; m_flushes = 0;
            end
            model_eval(e_pc, e_st, e_fl, e_bu, e_bk, e_nxt);
            check("pc_en", pc_en, e_pc);
            check("if_id_stall", if_id_stall, e_st);
            check("if_id_flush", if_id_flush, e_fl);
            check("id_ex_bubble", id_ex_bubble, e_bu);
            check("back_stall", back_stall, e_bk);
            check("stall_cnt", stall_cnt, sat(m_stalls, 16));
            check("flush_cnt", flush_cnt, sat(m_flushes, 16));
            check("stall_cnt4", stall_cnt4, sat(m_stalls, 4));
            check("flush_cnt4", flush_cnt4, sat(m_flushes, 4));
            @(posedge clk);
            if (rst) begin
                if (cpu_en && m_mode != M_HALT) begin
                    if (e_st) m_stalls++;
                    if (e_fl) m_flushes++;
                end
                m_mode = e_nxt;
            end else begin
                m_mode = M_HALT; m_stalls = 0; m_flushes = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cpu_en = 1; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
        ex_redirect = 0; ex_mem_read = 0; ex_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1;
    endtask

    initial begin
        set_idle();
        rst = 0;
        tick(); tick();
        rst = 1;

        // Reset release: one HALT cycle, then free running.
        @(negedge clk);
        check("halt_pc_en", pc_en, 0);
        check("halt_stall", if_id_stall, 1);
        tick();
        @(negedge clk);
        check("run_pc_en", pc_en, 1);
        check("run_stall_cnt", stall_cnt, 0);
        tick(); tick();

        // Load-use on rs2.
        set_load_use();
        @(negedge clk);
        check("lu_pc_en", pc_en, 0);
        check("lu_stall", if_id_stall, 1);
        check("lu_bubble", id_ex_bubble, 1);
        tick();
        set_idle();
        @(negedge clk);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_release_pc", pc_en, 1);

        // Load into x0 never stalls; with a redirect it is a pure flush.
        tick();
        ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
        @(negedge clk);
        check("x0_pc_en", pc_en, 1);
        check("x0_stall", if_id_stall, 0);
        tick();
        ex_redirect = 1;
        @(negedge clk);
        check("redir_flush", if_id_flush, 1);
        check("redir_bubble", id_ex_bubble, 1);
        check("redir_pc_en", pc_en, 1);
        tick();
        set_idle();
        @(negedge clk);
        check("redir_stall_cnt", stall_cnt, 1);
        check("redir_flush_cnt", flush_cnt, 1);

        // Data-memory wait of 3 cycles with a pending redirect.
        tick();
        dmem_req = 1; dmem_ready = 0; ex_redirect = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dw_back_stall", back_stall, 1);
            check("dw_flush", if_id_flush, 0);
            check("dw_bubble", id_ex_bubble, 0);
            tick();
        end
        dmem_ready = 1;
        @(negedge clk);
        check("dw_release_back", back_stall, 0);
        check("dw_release_flush", if_id_flush, 1);
        check("dw_release_pc", pc_en, 1);
        tick();
        set_idle();
        @(negedge clk);
        check("dw_stall_cnt", stall_cnt, 4);
        check("dw_flush_cnt", flush_cnt, 2);

        // Instruction-memory wait of 2 cycles.
        tick();
        imem_ready = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("iw_flush", if_id_flush, 1);
            check("iw_pc_en", pc_en, 0);
            tick();
        end
        imem_ready = 1;
        @(negedge clk);
        check("iw_release_pc", pc_en, 1);
        check("iw_flush_cnt", flush_cnt, 4);

        // Twenty back-to-back load-use stalls saturate the 4-bit counter.
        tick();
        set_load_use();
        repeat (20) tick();
        set_idle();
        @(negedge clk);
        check("sat_stall_cnt4", stall_cnt4, 15);
        check("sat_stall_cnt16", stall_cnt, 24);

        // Asynchronous reset in the middle of a data wait.
        tick();
        dmem_req = 1; dmem_ready = 0;
        tick(); tick();
        #2 rst = 0;
        #1;
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_flush_cnt", flush_cnt, 0);
        check("arst_stall_cnt4", stall_cnt4, 0);
        check("arst_back_stall", back_stall, 0);
        check("arst_pc_en", pc_en, 0);
        check("arst_if_id_stall", if_id_stall, 1);
        tick();
        set_idle();
        rst = 1;
        tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            cpu_en      = ($urandom_range(0, 19) != 0);
            imem_ready  = ($urandom_range(0, 99) < 85);
            dmem_req    = ($urandom_range(0, 99) < 30);
            dmem_ready  = ($urandom_range(0, 99) < 60);
            ex_redirect = ($urandom_range(0, 99) < 10);
            ex_mem_read = ($urandom_range(0, 99) < 35);
            ex_rd       = RAW'($urandom_range(0, 3));
            id_rs1      = RAW'($urandom_range(0, 3));
            id_rs2      = RAW'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            rst         = ($urandom_range(0, 399) != 0);
        end
        tick();
        set_idle();
        rst = 1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
